// File: rtl/vm_pkg.sv
// Shared types and default widths for the vending-machine credit path.
package vm_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DISPENSE = 2'd1,
    REFUND   = 2'd2
  } vm_state_e;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_COIN_W = 3;

endpackage

// File: rtl/adder_nbit.sv
// Ripple-carry adder built from single-bit full adder cells.
// Purely combinational; carry-out exposes overflow or no-borrow for subtraction.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];
endmodule

// File: rtl/coin_accumulator.sv
// Saturating credit accumulator: sums coins, vends against a price, or refunds on cancel.
// Coin visible on o_sum one edge later; vend/change requests hold until i_ack.
module coin_accumulator
  import vm_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int COIN_W = DEFAULT_COIN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_coin_valid,
  input  logic [COIN_W-1:0] i_coin,
  input  logic [WIDTH-1:0]  i_price,
  input  logic              i_cancel,
  input  logic              i_ack,
  output logic              o_coin_accept,
  output logic [WIDTH-1:0]  o_sum,
  output logic              o_vend,
  output logic [WIDTH-1:0]  o_change,
  output logic              o_change_valid,
  output logic              o_overflow
);

  vm_state_e        state_q, state_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] change_q, change_d;
  logic [WIDTH-1:0] price_q, price_d;
  logic             vend_q, vend_d;
  logic             change_valid_q, change_valid_d;
  logic             overflow_q, overflow_d;

  logic [WIDTH-1:0] coin_ext;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] sat_sum;
  logic [WIDTH-1:0] cmp_price;
  logic [WIDTH-1:0] diff;
  logic             sum_ge_price;
  logic             coin_accept;
  logic [WIDTH-1:0] refund_amt;

  assign coin_ext = WIDTH'(i_coin);

  adder_nbit #(.WIDTH(WIDTH)) u_credit_add (
    .a    (sum_q),
    .b    (coin_ext),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // While collecting, the live price drives the compare; afterwards the latched one.
  assign cmp_price = (state_q == COLLECT) ? i_price : price_q;

  adder_nbit #(.WIDTH(WIDTH)) u_change_sub (
    .a    (sum_q),
    .b    (~cmp_price),
    .cin  (1'b1),
    .sum  (diff),
    .cout (sum_ge_price)
  );

  assign sat_sum       = add_cout ? '1 : add_sum;
  assign coin_accept   = i_coin_valid && (state_q == COLLECT);
  assign o_coin_accept = coin_accept;
  assign refund_amt    = coin_accept ? sat_sum : sum_q;

  always_comb begin
    state_d        = state_q;
    sum_d          = sum_q;
    change_d       = change_q;
    price_d        = price_q;
    vend_d         = vend_q;
    change_valid_d = change_valid_q;
    overflow_d     = overflow_q;

    unique case (state_q)
      COLLECT: begin
        if (i_cancel) begin
          state_d        = REFUND;
          sum_d          = refund_amt;
          change_d       = refund_amt;
          change_valid_d = 1'b1;
          overflow_d     = overflow_q | (coin_accept & add_cout);
        end else if (coin_accept) begin
          // A coin wins over a price match; the match is re-tested on the new sum.
          sum_d      = sat_sum;
          overflow_d = overflow_q | add_cout;
        end else if ((i_price != '0) && sum_ge_price) begin
          state_d        = DISPENSE;
          price_d        = i_price;
          change_d       = diff;
          vend_d         = 1'b1;
          change_valid_d = 1'b1;
        end
      end
      DISPENSE, REFUND: begin
        if (i_ack) begin
          state_d        = COLLECT;
          sum_d          = '0;
          change_d       = '0;
          vend_d         = 1'b0;
          change_valid_d = 1'b0;
          overflow_d     = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= COLLECT;
      sum_q          <= '0;
      change_q       <= '0;
      price_q        <= '0;
      vend_q         <= 1'b0;
      change_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sum_q          <= sum_d;
      change_q       <= change_d;
      price_q        <= price_d;
      vend_q         <= vend_d;
      change_valid_q <= change_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign o_sum          = sum_q;
  assign o_vend         = vend_q;
  assign o_change       = change_q;
  assign o_change_valid = change_valid_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Directed bench for coin_accumulator with an arithmetic reference model checked every cycle.
module tb_coin_accumulator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       coin_valid = 1'b0;
  logic [2:0] coin = '0;
  logic [7:0] price = '0;
  logic       cancel = 1'b0;
  logic       ack = 1'b0;
  logic       coin_accept;
  logic [7:0] sum;
  logic       vend;
  logic [7:0] change;
  logic       change_valid;
  logic       overflow;

  int checks = 0;
  int failures = 0;

  coin_accumulator #(.WIDTH(8), .COIN_W(3)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_coin_valid   (coin_valid),
    .i_coin         (coin),
    .i_price        (price),
    .i_cancel       (cancel),
    .i_ack          (ack),
    .o_coin_accept  (coin_accept),
    .o_sum          (sum),
    .o_vend         (vend),
    .o_change       (change),
    .o_change_valid (change_valid),
    .o_overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: 0 = collecting, 1 = vending, 2 = refunding.
  int m_mode = 0;
  int m_sum = 0;
  int m_change = 0;
  int m_ovf = 0;

  always @(posedge clk or posedge rst) begin
    int total;
    if (rst) begin
      m_mode = 0; m_sum = 0; m_change = 0; m_ovf = 0;
    end else if (m_mode == 0) begin
      total = m_sum + (coin_valid ? int'(coin) : 0);
      if (total > 255) begin
        total = 255;
        m_ovf = 1;
      end
      if (cancel) begin
        m_sum = total; m_change = total; m_mode = 2;
      end else if (coin_valid) begin
        m_sum = total;
      end else if (price != 0 && m_sum >= int'(price)) begin
        m_change = m_sum - int'(price); m_mode = 1;
      end
    end else if (ack) begin
      m_mode = 0; m_sum = 0; m_change = 0; m_ovf = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("model_sum", int'(sum), m_sum);
      chk("model_vend", int'(vend), int'(m_mode == 1));
      chk("model_change", int'(change), m_change);
      chk("model_change_valid", int'(change_valid), int'(m_mode != 0));
      chk("model_overflow", int'(overflow), m_ovf);
      chk("model_coin_accept", int'(coin_accept), int'(coin_valid && m_mode == 0));
    end
  end

  task automatic drive(input bit cv, input logic [2:0] c, input bit cn, input bit ak);
    coin_valid = cv; coin = c; cancel = cn; ack = ak;
    @(posedge clk); #1;
    coin_valid = 1'b0; cancel = 1'b0; ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(0, 3'd0, 0, 0);
  endtask

  initial begin
    #3;
    chk("reset_sum", int'(sum), 0);
    chk("reset_vend", int'(vend), 0);
    chk("reset_change_valid", int'(change_valid), 0);
    chk("reset_overflow", int'(overflow), 0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // 1: exact payment
    price = 8'd10;
    drive(1, 3'd5, 0, 0);
    chk("t1_sum5", int'(sum), 5);
    drive(1, 3'd5, 0, 0);
    chk("t1_sum10", int'(sum), 10);
    chk("t1_no_vend_yet", int'(vend), 0);
    idle(1);
    chk("t1_vend", int'(vend), 1);
    chk("t1_change", int'(change), 0);
    drive(0, 3'd0, 0, 1);
    chk("t1_sum_cleared", int'(sum), 0);
    chk("t1_vend_cleared", int'(vend), 0);

    // 2: change held while waiting for ack
    price = 8'd7;
    drive(1, 3'd5, 0, 0);
    drive(1, 3'd5, 0, 0);
    idle(1);
    chk("t2_vend", int'(vend), 1);
    for (int k = 0; k < 4; k++) begin
      idle(1);
      chk("t2_change_held", int'(change), 3);
    end
    drive(0, 3'd0, 0, 1);
    chk("t2_change_cleared", int'(change), 0);

    // 3: saturation
    price = 8'd255;
    for (int k = 0; k < 36; k++) drive(1, 3'd7, 0, 0);
    chk("t3_sum252", int'(sum), 252);
    chk("t3_no_ovf", int'(overflow), 0);
    drive(1, 3'd7, 0, 0);
    chk("t3_sum_sat", int'(sum), 255);
    chk("t3_ovf", int'(overflow), 1);
    idle(1);
    chk("t3_vend", int'(vend), 1);
    chk("t3_change", int'(change), 0);
    drive(0, 3'd0, 0, 1);
    chk("t3_ovf_cleared", int'(overflow), 0);

    // 4: cancel with same-cycle coin
    price = 8'd0;
    drive(1, 3'd6, 0, 0);
    drive(1, 3'd2, 1, 0);
    chk("t4_refund", int'(change), 8);
    chk("t4_refund_valid", int'(change_valid), 1);
    chk("t4_no_vend", int'(vend), 0);
    drive(0, 3'd0, 0, 1);
    chk("t4_cleared", int'(change_valid), 0);

    // 5: coins, cancel and price changes ignored while vending; price 0 never vends
    price = 8'd3;
    drive(1, 3'd4, 0, 0);
    idle(1);
    chk("t5_vend", int'(vend), 1);
    chk("t5_change", int'(change), 1);
    coin_valid = 1'b1; coin = 3'd4;
    #1 chk("t5_coin_rejected", int'(coin_accept), 0);
    drive(1, 3'd4, 0, 0);
    chk("t5_sum_unchanged", int'(sum), 4);
    drive(0, 3'd0, 1, 0);
    chk("t5_cancel_ignored", int'(vend), 1);
    price = 8'd1;
    idle(1);
    chk("t5_price_held", int'(change), 1);
    drive(0, 3'd0, 0, 1);
    price = 8'd0;
    drive(1, 3'd7, 0, 0);
    idle(3);
    chk("t5_sum7", int'(sum), 7);
    chk("t5_price0_no_vend", int'(vend), 0);
    drive(0, 3'd0, 1, 0);
    drive(0, 3'd0, 0, 1);

    // 6: asynchronous reset mid-dispense
    price = 8'd2;
    drive(1, 3'd3, 0, 0);
    idle(1);
    chk("t6_vend", int'(vend), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_async_vend", int'(vend), 0);
    chk("t6_async_change_valid", int'(change_valid), 0);
    chk("t6_async_sum", int'(sum), 0);
    #1 rst = 1'b0;
    price = 8'd0;
    @(posedge clk); #1;
    drive(1, 3'd5, 0, 0);
    chk("t6_after_sum", int'(sum), 5);
    drive(0, 3'd0, 1, 0);
    chk("t6_after_refund", int'(change), 5);
    drive(0, 3'd0, 0, 1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
